// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing helpers for the FIFO read-side stream consumer.
// Burst grouping is compiled in with `define FIFO_READER_BURST_EN.
package fifo_reader_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_st_e;

  // Skid occupancy spans 0..2
  localparam int OCC_W = 2;

  // Fetch counter and captured length must hold BURST_LEN up to 2**depth_w
  function automatic int fetch_cnt_w(input int depth_w);
    return depth_w + 1;
  endfunction

  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry data+last skid buffer. The head register drives the stream output
// directly, so output data is always registered and stable while stalled.
module stream_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  drain,
  output logic [OCC_W-1:0]      occ,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t head_q, tail_q, in_ent;
  logic [OCC_W-1:0] occ_q;

  assign in_ent = '{last: push_last, data: push_data};

  // Pushes arriving at occ=2 cannot happen: the producer gates on occ<2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      case (occ_q)
        OCC_W'(0): begin
          if (push) begin
            head_q <= in_ent;
            occ_q  <= OCC_W'(1);
          end
        end
        OCC_W'(1): begin
          case ({push, drain})
            2'b10: begin
              tail_q <= in_ent;
              occ_q  <= OCC_W'(2);
            end
            2'b01: occ_q <= OCC_W'(0);
            2'b11: head_q <= in_ent;
            default: ;
          endcase
        end
        OCC_W'(2): begin
          if (drain) begin
            head_q <= tail_q;
            occ_q  <= OCC_W'(1);
          end
        end
        default: occ_q <= '0;
      endcase
    end
  end

  assign occ       = occ_q;
  assign out_valid = (occ_q != '0);
  assign out_data  = head_q.data;
  assign out_last  = head_q.last;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: pops a FWFT FIFO into a registered valid/ready stream.
// Define FIFO_READER_BURST_EN to group words into m_last-terminated bursts.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH_WIDTH = 11,
  parameter int BURST_LEN        = 16,
  parameter int TIMEOUT          = 64
) (
  input  logic                        clk_read,
  input  logic                        rst_n,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic [FIFO_DEPTH_WIDTH-1:0] fifo_count,
  output logic                        fifo_read,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last
);

  logic [OCC_W-1:0] occ;
  logic             fetch_en;
  logic             pop;
  logic             pop_last;
  logic             drain;

  // Gated by rst_n so no word is consumed while the skid is held in reset
  assign pop       = rst_n && !fifo_empty && (occ < OCC_W'(2)) && fetch_en;
  assign fifo_read = pop;
  assign drain     = m_valid && m_ready;

`ifdef FIFO_READER_BURST_EN
  localparam int CW = fetch_cnt_w(FIFO_DEPTH_WIDTH);
  localparam int TW = tmo_cnt_w(TIMEOUT);

  burst_st_e       state_q, state_d;
  logic [CW-1:0]   fetch_cnt_q;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   count_ext;
  logic [TW-1:0]   tmo_q;
  logic            start;
  logic            burst_done;

  assign count_ext  = {1'b0, fifo_count};
  assign burst_done = (state_q == ST_BURST) && pop && ((fetch_cnt_q + 1'b1) == len_q);
  assign pop_last   = burst_done;

  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      fetch_cnt_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q <= state_d;
      if (start) len_q <= len_d;
      if ((state_q == ST_BURST) && pop)
        fetch_cnt_q <= burst_done ? '0 : fetch_cnt_q + 1'b1;
      if (fifo_empty || start || (state_q == ST_BURST))
        tmo_q <= '0;
      else if (tmo_q != TW'(TIMEOUT))
        tmo_q <= tmo_q + 1'b1;
    end
  end

  // A full burst takes priority; a timeout flush drains whatever is resident,
  // at least one word since fifo_count may lag the empty flag.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (count_ext >= CW'(BURST_LEN)) begin
          start = 1'b1;
          len_d = CW'(BURST_LEN);
        end else if (tmo_q == TW'(TIMEOUT)) begin
          start = 1'b1;
          len_d = (fifo_count == '0) ? CW'(1) : count_ext;
        end
        if (start) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (burst_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_en = (state_q == ST_BURST);
  end
`else
  logic unused_cfg;

  assign fetch_en   = 1'b1;
  assign pop_last   = 1'b0;
  assign unused_cfg = &{1'b0, fifo_count, (BURST_LEN > 0), (TIMEOUT > 0)};
`endif

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk_read),
    .rst_n     (rst_n),
    .push      (pop),
    .push_data (fifo_data),
    .push_last (pop_last),
    .drain     (drain),
    .occ       (occ),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_last  (m_last)
  );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for the dual-clock FIFO, in the FIFO's read clock domain. Pops words from the FIFO read port and presents them as a registered valid/ready stream through a 2-entry skid buffer, sustaining one word per cycle. With burst mode compiled in, it groups words into fixed-length bursts terminated by `m_last`, and issues a short flush burst after an idle timeout.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `FIFO_DEPTH_WIDTH`, 11: FIFO address width; the occupancy input is this wide.
- `BURST_LEN`, 16: words per full burst, 1..2**FIFO_DEPTH_WIDTH.
- `TIMEOUT`, 64: idle cycles with a non-empty FIFO before a flush burst starts; must be ≥1.
- `clk_read` input 1: single clock, the FIFO read clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_data` input DATA_WIDTH: FIFO head word, valid whenever `!fifo_empty`.
- `fifo_count` input FIFO_DEPTH_WIDTH: read-side occupancy; a stale lower bound.
- `fifo_read` output 1: pop strobe, combinational.
- `m_valid` output 1: output word valid.
- `m_ready` input 1: downstream accept.
- `m_data` output DATA_WIDTH: output word.
- `m_last` output 1: final word of a burst.

## Operation
- **FIFO protocol is first-word-fall-through.**
  - `fifo_read && !fifo_empty` at an edge consumes the head word.
  - The next head word and the updated `fifo_empty` are valid after that edge.
- **Pop rule:** `fifo_read = !fifo_empty && (occ < 2) && fetch_en`.
  - `occ` is the skid occupancy, 0..2.
  - `fifo_read` is never asserted while `fifo_empty` is high.
  - It is forced to 0 while `rst_n` is low.
- **Skid buffer:**
  - Each cycle it may push one word (on pop) and drain one word (on `m_valid && m_ready`).
  - Both in the same cycle leave `occ` unchanged.
  - Words leave in FIFO order.
  - `m_last` travels with its word.
- **Without burst mode:** `fetch_en = 1` and `m_last = 0`.
- **Burst FSM (burst mode only), states IDLE, BURST:**
  - IDLE → BURST with `len = BURST_LEN` when `fifo_count >= BURST_LEN`.
  - Otherwise IDLE → BURST with `len = max(1, fifo_count)` when the timeout counter reaches TIMEOUT.
  - Timeout counter: increments in IDLE while `!fifo_empty`; clears on `fifo_empty` and on entering BURST.
  - In BURST, `fetch_en = 1`. A fetch counter (FIFO_DEPTH_WIDTH+1 bits) counts pops.
  - The pop bringing the count to `len` tags its word `m_last = 1` and returns the FSM to IDLE the next cycle.
  - In IDLE, `fetch_en = 0`.
  - `fifo_empty` mid-burst stalls the fetch; the burst is never truncated.
- **Arithmetic:** all compares are unsigned. `len` is captured at the transition, so later changes to `fifo_count` do not affect it.

## Timing
- **Reset values:**
  - `m_valid = 0`, `m_data = 0`, `m_last = 0`.
  - `occ = 0`, FSM = IDLE, all counters = 0.
- **Reset mid-burst:** the skid contents and the partial burst are discarded. No `m_last` is emitted afterwards for that burst.
- **Latency:** a word popped at edge N is on `m_data` with `m_valid = 1` after edge N, i.e. visible in cycle N+1.
- **Throughput:** one word per cycle with `m_ready` held high and the FIFO non-empty.
- **Backpressure:**
  - While `m_valid && !m_ready`, `m_data` and `m_last` are stable.
  - Pops continue until `occ = 2`.
- **Ready release:** when `m_ready` rises with `occ = 2`, the next word is presented on the next cycle with no bubble.
- **Burst spacing:** at least one idle cycle (IDLE state) between bursts.

## Configuration
- `FIFO_READER_BURST_EN` defined: the burst FSM, fetch counter and timeout counter are present, and `m_last` is driven.
- Not defined: pure streaming; `m_last` is tied to 0, and `BURST_LEN` and `TIMEOUT` are unused.

## Structure
- Package `fifo_reader_pkg`:
  - FSM state encoding (IDLE, BURST).
  - Skid occupancy width (2 bits).
  - Counter width `$clog2(TIMEOUT+1)`, helper for the fetch counter width.
- Sub-module `stream_skid_buf`: 2-entry data+last skid buffer with push/drain and `occ` output.
- The top level holds the pop logic and the FSM.

## Test plan
- **Streaming, macro off:** preload 5 words 0x11..0x15, `m_ready` held 1 → `m_data` 0x11..0x15 on 5 consecutive cycles starting one cycle after the first pop; `m_last = 0`.
- **Backpressure:** `m_ready` low 4 cycles with the FIFO holding 8 words → exactly 2 pops, then `fifo_read` held 0; `m_data` stable. When `m_ready` rises, all 8 words arrive in order with no gap.
- **Full burst (`BURST_LEN = 4`):** FIFO fills to 6 → 4 words out with `m_last` on word 4. FSM returns to IDLE; the remaining 2 words wait for the timeout.
- **Timeout flush (`TIMEOUT = 8`):** 3 words resident, `fifo_count = 3` → after 8 cycles a 3-word burst with `m_last` on word 3.
- **Mid-burst underflow:** `BURST_LEN = 4`, `fifo_empty` asserts after 2 pops for 5 cycles → stall, then words 3–4 follow and `m_last` is on word 4.
- **Reset mid-burst:** assert `rst_n = 0` after word 2 of 4 → `m_valid`, `m_last` and `fifo_read` go 0 immediately; after release, FSM = IDLE and `occ = 0`.
